// File: rtl/ask_pkg.sv
// ask_pkg: shared state type and arithmetic helpers for the ASK slicer.
// Contents: ask_state_t (HUNT/LOCK), abs_diff (|a-b| one bit wider than the
// operands), to_gray (binary to reflected Gray code).
package ask_pkg;
    typedef enum logic {HUNT, LOCK} ask_state_t;
    localparam int ABS_W = 32;
    function automatic logic [ABS_W:0] abs_diff(input logic signed [ABS_W-1:0] a, input logic signed [ABS_W-1:0] b);
        logic [ABS_W:0] d;
        d = {a[ABS_W-1], a} - {b[ABS_W-1], b};
        return d[ABS_W] ? -d : d;
    endfunction
    function automatic logic [7:0] to_gray(input logic [7:0] b);
        return b ^ (b >> 1);
    endfunction
endpackage

// File: rtl/ask_window.sv
// ask_window: 3-sample envelope history, settle detector and level quantiser.
// Ports: clk, reset_n (async active-low), in/in_valid (signed envelope),
// stable (all pairwise |dx-dy| <= BW once primed), level (quantised d1),
// primed (three samples accepted since reset).
module ask_window import ask_pkg::*; #(
    parameter int INPUT_WIDTH = 16,
    parameter int LEVEL_BITS  = 3
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [INPUT_WIDTH-1:0] in,
    input  logic                   in_valid,
    output logic                   stable,
    output logic [LEVEL_BITS-1:0]  level,
    output logic                   primed
);
    localparam int SH = INPUT_WIDTH - LEVEL_BITS;
    localparam logic [ABS_W:0] BW = (ABS_W+1)'(1) << SH;
    logic [INPUT_WIDTH-1:0] r_d1, r_d2, r_d3;
    logic [1:0]             r_fill;
    logic [INPUT_WIDTH:0]   w_off;
    logic [ABS_W-1:0]       w_a1, w_a2, w_a3;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_d1   <= '0;
            r_d2   <= '0;
            r_d3   <= '0;
            r_fill <= '0;
        end else if (in_valid) begin
            r_d1 <= in;
            r_d2 <= r_d1;
            r_d3 <= r_d2;
            if (r_fill != 2'd3) r_fill <= r_fill + 2'd1;
        end
    end
    assign primed = r_fill == 2'd3;
    assign w_a1   = ABS_W'($signed(r_d1));
    assign w_a2   = ABS_W'($signed(r_d2));
    assign w_a3   = ABS_W'($signed(r_d3));
    assign stable = primed && abs_diff(w_a1, w_a2) <= BW && abs_diff(w_a2, w_a3) <= BW
                    && abs_diff(w_a1, w_a3) <= BW;
    // Offset-binary in one extra bit, so full-scale inputs never wrap.
    assign w_off  = {r_d1[INPUT_WIDTH-1], r_d1} + ((INPUT_WIDTH+1)'(1) << (INPUT_WIDTH-1));
    assign level  = LEVEL_BITS'(w_off >> SH);
endmodule

// File: rtl/ask_slicer.sv
// ask_slicer: ASK symbol slicer with level-transition timing recovery.
// Ports: clk, reset_n (async active-low), in/in_valid (envelope stream),
// symbol_len (samples per symbol, min 2), min_run (lock run length, min 1),
// out/out_valid/out_ready (single-entry symbol output), locked (FSM in LOCK,
// one clock late), overrun/mid_err (sticky error flags).
// Option: define ASK_SLICER_GRAY_EN to emit Gray-coded symbols.
module ask_slicer import ask_pkg::*; #(
    parameter int INPUT_WIDTH = 16,
    parameter int LEVEL_BITS  = 3,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [INPUT_WIDTH-1:0] in,
    input  logic                   in_valid,
    input  logic [CNT_WIDTH-1:0]   symbol_len,
    input  logic [7:0]             min_run,
    output logic [LEVEL_BITS-1:0]  out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   locked,
    output logic                   overrun,
    output logic                   mid_err
);
    localparam logic [CNT_WIDTH-1:0] C_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH:0]   S_ONE = (CNT_WIDTH+1)'(1);
    ask_state_t            r_state, w_state_n;
    logic [7:0]            r_run, w_run_n, w_run_inc, w_mr;
    logic [LEVEL_BITS-1:0] r_prev_lvl, w_prev_n, r_last_lvl, w_last_n, r_emit_lvl, w_sym, w_level;
    logic [CNT_WIDTH-1:0]  r_cnt, w_cnt_n, w_cnt_upd, w_sl;
    logic [CNT_WIDTH:0]    r_stall, w_stall_n;
    logic                  r_emit, w_emit_n, r_mid_err, w_mid_n, w_mid_pt, w_resync;
    logic                  r_locked, r_out_valid, r_overrun, w_stable, w_primed;
    logic [LEVEL_BITS-1:0] r_out;
    ask_window #(.INPUT_WIDTH(INPUT_WIDTH), .LEVEL_BITS(LEVEL_BITS)) u_window (
        .clk(clk), .reset_n(reset_n), .in(in), .in_valid(in_valid),
        .stable(w_stable), .level(w_level), .primed(w_primed)
    );
    assign w_sl      = symbol_len < CNT_WIDTH'(2) ? CNT_WIDTH'(2) : symbol_len;
    assign w_mr      = min_run == 8'd0 ? 8'd1 : min_run;
    assign w_run_inc = (w_stable && r_run != 8'd0 && w_level == r_prev_lvl) ? r_run + 8'd1 : {7'd0, w_stable};
    assign w_resync  = w_stable && w_level != r_last_lvl;
    assign w_cnt_upd = (w_resync || r_cnt == w_sl - C_ONE) ? '0 : r_cnt + C_ONE;
    assign w_mid_pt  = w_cnt_upd == (w_sl >> 1);
    always_comb begin
        w_state_n = r_state;
        w_run_n   = r_run;
        w_prev_n  = r_prev_lvl;
        w_cnt_n   = r_cnt;
        w_last_n  = r_last_lvl;
        w_stall_n = r_stall;
        w_emit_n  = 1'b0;
        w_mid_n   = r_mid_err;
        if (in_valid) begin
            w_prev_n = w_level;
            if (r_state == HUNT) begin
                w_run_n = w_run_inc;
                if (w_run_inc >= w_mr) begin
                    w_state_n = LOCK;
                    w_cnt_n   = '0;
                    w_last_n  = w_level;
                    w_stall_n = '0;
                end
            end else begin
                w_cnt_n   = w_cnt_upd;
                w_last_n  = w_resync ? w_level : r_last_lvl;
                w_stall_n = w_stable ? '0 : r_stall + S_ONE;
                w_emit_n  = w_stable && w_mid_pt;
                w_mid_n   = r_mid_err | (!w_stable && w_mid_pt);
                if (w_stall_n == {w_sl, 1'b0}) begin
                    w_state_n = HUNT;
                    w_run_n   = '0;
                end
            end
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= HUNT;
            r_run      <= '0;
            r_prev_lvl <= '0;
            r_cnt      <= '0;
            r_last_lvl <= '0;
            r_stall    <= '0;
            r_emit     <= 1'b0;
            r_emit_lvl <= '0;
            r_mid_err  <= 1'b0;
            r_locked   <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_run      <= w_run_n;
            r_prev_lvl <= w_prev_n;
            r_cnt      <= w_cnt_n;
            r_last_lvl <= w_last_n;
            r_stall    <= w_stall_n;
            r_emit     <= w_emit_n;
            r_mid_err  <= w_mid_n;
            r_locked   <= r_state == LOCK;
            if (w_emit_n) r_emit_lvl <= w_level;
        end
    end
`ifdef ASK_SLICER_GRAY_EN
    assign w_sym = LEVEL_BITS'(to_gray(8'(r_emit_lvl)));
`else
    assign w_sym = r_emit_lvl;
`endif
    // A pending emit is dropped only when the held symbol is not taken this cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else if (r_emit) begin
            if (r_out_valid && !out_ready) begin
                r_overrun <= 1'b1;
            end else begin
                r_out       <= w_sym;
                r_out_valid <= 1'b1;
            end
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end
    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign locked    = r_locked;
    assign overrun   = r_overrun;
    assign mid_err   = r_mid_err;
endmodule

// File: doc/ask_slicer.md
# ask_slicer

Amplitude-shift-keyed symbol slicer sitting directly downstream of `am_demod`. Consumes the demodulated envelope stream (`out`/`out_valid` of `am_demod`), checks that the envelope has settled, quantises it to one of 2^LEVEL_BITS levels, recovers symbol timing from level transitions, and emits one symbol per symbol period through a valid/ready handshake.

## Interface
- `INPUT_WIDTH`, 16: width of the signed envelope input; matches `am_demod` OUTPUT_WIDTH.
- `LEVEL_BITS`, 3: bits per symbol; there are 2^LEVEL_BITS levels.
- `CNT_WIDTH`, 16: width of the symbol-length and timing counters.

- `clk`  in  1: clock; all logic is rising-edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `in`  in  INPUT_WIDTH: signed envelope sample.
- `in_valid`  in  1: `in` is valid this cycle. There is no backpressure, so every valid sample is accepted.
- `symbol_len`  in  CNT_WIDTH: accepted samples per symbol. Values below 2 are treated as 2.
- `min_run`  in  8: number of consecutive stable, same-level samples required to lock. A value of 0 is treated as 1.
- `out`  out  LEVEL_BITS: sliced symbol.
- `out_valid`  out  1: `out` is valid.
- `out_ready`  in  1: consumer accepts `out`.
- `locked`  out  1: the FSM is in LOCK.
- `overrun`  out  1: sticky flag. Set when a symbol is dropped because the output was full.
- `mid_err`  out  1: sticky flag. Set when the mid-symbol sample was unstable.

## Operation
- **Bandwidth.** BW = 2^(INPUT_WIDTH-LEVEL_BITS).
- **Level.** level = (in + 2^(INPUT_WIDTH-1)) >> (INPUT_WIDTH-LEVEL_BITS). The addition is done in INPUT_WIDTH+1 bits, so there is no saturation or overflow. Examples at the defaults: -32768 gives 0, 0 gives 4, 32767 gives 7.
- **History.** A 3-deep history d1/d2/d3 shifts on each `in_valid`.
- **Stable.** `stable` is true when all three pairwise |dx−dy| ≤ BW, computed in INPUT_WIDTH+1 bits. It is forced false until three samples have been accepted since reset.
- **Sampled level.** The level of d1.
- **FSM: HUNT.**
  - `run` counts consecutive accepted samples that are stable and have the same level.
  - An unstable sample or a level change reloads `run` to 1 if stable, otherwise 0.
  - When `run` ≥ `min_run`, the FSM goes to LOCK with `cnt` = 0 and `last_level` = the current level.
- **FSM: LOCK.** On each accepted sample:
  - **Resync.** If stable and level ≠ `last_level`, then `cnt` := 0 and `last_level` := level.
  - **Otherwise,** `cnt` := (`cnt` == `symbol_len`−1) ? 0 : `cnt`+1.
  - **Emit.** When the post-update `cnt` == `symbol_len`>>1:
    - if stable, emit the current level;
    - otherwise emit nothing and set `mid_err`.
  - **Stall.** `stall` counts consecutive unstable samples. When it reaches 2·`symbol_len`, the FSM returns to HUNT with `run` = 0.
- **Output register.** Single entry.
  - An emit while `out_valid` && !`out_ready` drops the new symbol and sets `overrun`.
  - An emit in the same cycle as a handshake (`out_valid` && `out_ready`) loads the new symbol, and `out_valid` stays 1.
- **Configuration inputs.** `symbol_len` and `min_run` are sampled continuously. Changes are legal only while `locked` = 0.

## Timing
- **Reset values.** `out` = 0, `out_valid` = 0, `locked` = 0, `overrun` = 0, `mid_err` = 0. The FSM is in HUNT, and all counters and history are cleared.
- **History latency.** A sample presented with `in_valid` at edge n is in d1 after edge n.
- **Stability and level.** Both are combinational from d1..d3 and are registered into the FSM at the next accepted sample. When the FSM decides an emit on the edge that accepts sample n, `out_valid` rises at edge n+1. Latency from the in_valid sample to `out_valid` is therefore 2 clocks.
- **LOCK entry.** `locked` rises one clock after the FSM enters LOCK.
- **Reset during operation.** Asserting `reset_n` low at any point clears everything immediately, including a pending `out_valid`. No symbol is emitted until lock is reacquired.
- **Gaps in `in_valid`.** Gaps freeze all counters and the history. Timing counts accepted samples, not clocks.

## Configuration
- `ASK_SLICER_GRAY_EN`
  - **Defined:** `out` carries the Gray code of the level, level ^ (level>>1), applied at the output register.
  - **Undefined:** `out` carries the binary level.
  - **Unaffected:** `last_level` and all comparisons use binary in both cases.

## Structure
- **Package `ask_pkg`:**
  - state typedef `ask_state_t` {HUNT, LOCK};
  - function `abs_diff`, which returns the absolute difference at width+1;
  - function `to_gray`.
- **Sub-module `ask_window`:** holds the 3-sample history, the `stable` computation and the quantiser. Its outputs are `stable`, `level` and `primed`.
- **`ask_slicer` itself:** contains the FSM, the counters and the output register.

## Test plan
- **Constant envelope.** `in` = 0 on every cycle, `min_run` = 4, `symbol_len` = 8 → `locked` rises. `out` = 4 (6 with Gray), with one `out_valid` every 8 samples. `mid_err` stays 0.
- **Level step.** 40 samples at -32768 then 40 samples at 32767, `symbol_len` = 8 → symbols 0, 0, 0, … then 7, 7, …. The first 7 appears 4 accepted samples after the step settles, which shows resync on the edge.
- **Overrun.** Constant input with `out_ready` = 0 → the first symbol is held, the second emit sets `overrun`, and `out` is unchanged. Raising `out_ready` completes a handshake, and the next emit loads normally.
- **Noise.** Alternate ±20000 on every sample while in LOCK with `symbol_len` = 8 → `mid_err` sets, and `locked` drops after 16 unstable samples.
- **Reset during operation.** Pulse `reset_n` low while `out_valid` = 1 → `out_valid`, `locked` and the flags clear asynchronously. Relock takes 3 + `min_run` samples.
- **Sparse input.** `in_valid` asserted on every 3rd cycle with a constant input → the symbol period is `symbol_len` accepted samples, i.e. 24 clocks for `symbol_len` = 8.
